bloom_scan_ctrl: RTL and testbench

//  Scan master for the peak/notation memory. Walks addresses 0..MEM_LEN-1, reads each packed

---
 rtl/bloom_scan_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_bloom_scan_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bloom_scan_ctrl.sv
// bloom_scan_ctrl: scan master for the peak/notation memory.
// Walks every pixel word, classifies each peak as empty / saturated /
// bloom / valid, and writes the 2-bit notations back to the same address.
// Optional feature macro: BLOOM_STATS_EN (per-pass bloom-peak counter).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; outputs hold
// ADDR  | address presented; memory samples it at the closing edge
// EVAL  | pixel word valid; classify and load notation + write strobe
// WRITE | write strobe high, address/notation held for the negedge write
// DONE  | last pixel written; pulse bloom_end and drop busy
module bloom_scan_ctrl #(
  parameter int                      SIGNAL_WIDTH = 18,
  parameter int                      DIST_WIDTH   = 14,
  parameter int                      PEAK_NUM     = 4,
  parameter int                      NOT_WIDTH    = 2 * PEAK_NUM,
  parameter int                      DATA_WIDTH   = (SIGNAL_WIDTH + DIST_WIDTH) * PEAK_NUM,
  parameter int                      ADDR_WIDTH   = 5,
  parameter int                      MEM_LEN      = 30,
  parameter logic [SIGNAL_WIDTH-1:0] SAT_THR      = 18'h3FFF0,
  parameter logic [DIST_WIDTH-1:0]   DIST_TOL     = 14'd8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] o_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic                  o_wr_en,
  output logic [NOT_WIDTH-1:0]  o_point_notation,
  output logic                  o_bloom_end,
  output logic [15:0]           o_bloom_cnt
);

  localparam int PEAK_W = SIGNAL_WIDTH + DIST_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_EVAL  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                              r_state;
  logic                                r_busy;
  logic [ADDR_WIDTH-1:0]               r_addr;
  logic                                r_wr_en;
  logic [NOT_WIDTH-1:0]                r_notation;
  logic                                r_bloom_end;
  // Saturated distances of the previous pixel (bloom neighbours)
  logic [PEAK_NUM-1:0]                 r_prev_vld;
  logic [PEAK_NUM-1:0][DIST_WIDTH-1:0] r_prev_dist;
  // Current pixel's saturated distances, promoted to r_prev_* once written
  logic [PEAK_NUM-1:0]                 r_pend_vld;
  logic [PEAK_NUM-1:0][DIST_WIDTH-1:0] r_pend_dist;

  logic [PEAK_NUM-1:0][SIGNAL_WIDTH-1:0] w_sig;
  logic [PEAK_NUM-1:0][DIST_WIDTH-1:0]   w_dist;
  logic [PEAK_NUM-1:0]                   w_cur_sat;
  logic [PEAK_NUM-1:0]                   w_near;
  logic [NOT_WIDTH-1:0]                  w_notation;

  // Absolute distance difference evaluated one bit wider, so no wrap-around
  function automatic logic dist_near(input logic [DIST_WIDTH-1:0] a,
                                     input logic [DIST_WIDTH-1:0] b);
    logic signed [DIST_WIDTH:0] diff;
    logic signed [DIST_WIDTH:0] mag;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    mag  = (diff < 0) ? -diff : diff;
    return (mag <= $signed({1'b0, DIST_TOL}));
  endfunction

  // Unpack the pixel word and classify every peak in priority order
  always_comb begin
    w_sig      = '0;
    w_dist     = '0;
    w_cur_sat  = '0;
    w_near     = '0;
    w_notation = '0;
    for (int k = 0; k < PEAK_NUM; k++) begin
      w_sig[k]     = i_mem_data[(k+1)*PEAK_W-1 -: SIGNAL_WIDTH];
      w_dist[k]    = i_mem_data[k*PEAK_W +: DIST_WIDTH];
      w_cur_sat[k] = (w_sig[k] != '0) && (w_sig[k] >= SAT_THR);
    end
    for (int k = 0; k < PEAK_NUM; k++) begin
      for (int j = 0; j < PEAK_NUM; j++) begin
        if (w_cur_sat[j] && dist_near(w_dist[k], w_dist[j]))
          w_near[k] = 1'b1;
        if (r_prev_vld[j] && dist_near(w_dist[k], r_prev_dist[j]))
          w_near[k] = 1'b1;
      end
    end
    for (int k = 0; k < PEAK_NUM; k++) begin
      if (w_sig[k] == '0)
        w_notation[2*k +: 2] = 2'b11;
      else if (w_cur_sat[k])
        w_notation[2*k +: 2] = 2'b01;
      else if (w_near[k])
        w_notation[2*k +: 2] = 2'b10;
      else
        w_notation[2*k +: 2] = 2'b00;
    end
  end

  // Scan sequencer with registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_addr      <= '0;
      r_wr_en     <= 1'b0;
      r_notation  <= '0;
      r_bloom_end <= 1'b0;
      r_prev_vld  <= '0;
      r_prev_dist <= '0;
      r_pend_vld  <= '0;
      r_pend_dist <= '0;
    end else begin
      r_bloom_end <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_addr     <= '0;
            r_busy     <= 1'b1;
            r_prev_vld <= '0;
            r_state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          r_notation  <= w_notation;
          r_wr_en     <= 1'b1;
          r_pend_vld  <= w_cur_sat;
          r_pend_dist <= w_dist;
          r_state     <= S_WRITE;
        end
        S_WRITE: begin
          r_wr_en     <= 1'b0;
          r_prev_vld  <= r_pend_vld;
          r_prev_dist <= r_pend_dist;
          if (r_addr == LAST_ADDR) begin
            r_state <= S_DONE;
          end else begin
            r_addr  <= r_addr + ADDR_WIDTH'(1);
            r_state <= S_ADDR;
          end
        end
        S_DONE: begin
          r_bloom_end <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef BLOOM_STATS_EN
  localparam int CNT_W = $clog2(PEAK_NUM + 1);

  logic [15:0]      r_bloom_cnt;
  logic [CNT_W-1:0] w_nbloom;
  logic [16:0]      w_cnt_sum;

  // Number of bloom notations in the word about to be written
  always_comb begin
    w_nbloom = '0;
    for (int k = 0; k < PEAK_NUM; k++) begin
      if (w_notation[2*k +: 2] == 2'b10)
        w_nbloom = w_nbloom + CNT_W'(1);
    end
    w_cnt_sum = {1'b0, r_bloom_cnt} + 17'(w_nbloom);
  end

  // Saturating per-pass bloom counter, cleared when a pass is accepted
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bloom_cnt <= '0;
    end else if (r_state == S_IDLE && i_start) begin
      r_bloom_cnt <= '0;
    end else if (r_state == S_EVAL) begin
      r_bloom_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end
  end

  assign o_bloom_cnt = r_bloom_cnt;
`else
  assign o_bloom_cnt = 16'd0;
`endif

  assign o_busy           = r_busy;
  assign o_addr           = r_addr;
  assign o_wr_en          = r_wr_en;
  assign o_point_notation = r_notation;
  assign o_bloom_end      = r_bloom_end;

endmodule

// File: tb/tb_bloom_scan_ctrl.sv
// Testbench for bloom_scan_ctrl: registered-address memory model, negedge
// notation capture, and a pixel-level reference model of the classification.
module tb_bloom_scan_ctrl;

  localparam int MEM_LEN = 30;
  localparam int SAT     = 'h3FFF0;
  localparam int TOL     = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         busy;
  logic [4:0]   addr;
  logic [127:0] mem_data;
  logic         wr_en;
  logic [7:0]   pn;
  logic         bloom_end;
  logic [15:0]  bloom_cnt;

  logic [127:0] mem      [32];
  logic [4:0]   mem_raddr;
  logic [7:0]   got_not  [32];
  int           got_pass [32];
  int           wr_cnt   = 0;
  int           pass_id  = 0;
  logic [7:0]   exp_not  [MEM_LEN];
  int           exp_bloom;
  int           n_cmp    = 0;
  int           n_err    = 0;

  bloom_scan_ctrl dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_start          (start),
    .o_busy           (busy),
    .o_addr           (addr),
    .i_mem_data       (mem_data),
    .o_wr_en          (wr_en),
    .o_point_notation (pn),
    .o_bloom_end      (bloom_end),
    .o_bloom_cnt      (bloom_cnt)
  );

  always #5 clk = ~clk;

  // Memory: address registered on posedge, data valid the following cycle
  always @(posedge clk) mem_raddr <= addr;
  assign mem_data = mem[mem_raddr];

  // Notation write port on negedge
  always @(negedge clk) begin
    if (wr_en) begin
      got_not[addr]  = pn;
      got_pass[addr] = pass_id;
      wr_cnt++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int s, input int d);
    logic [31:0] s_v;
    logic [31:0] d_v;
    s_v = s;
    d_v = d;
    return {s_v[17:0], d_v[13:0]};
  endfunction

  function automatic int sig_of(input int p, input int k);
    logic [31:0] w;
    w = mem[p][k*32 +: 32];
    return int'(w[31:14]);
  endfunction

  function automatic int dist_of(input int p, input int k);
    logic [31:0] w;
    w = mem[p][k*32 +: 32];
    return int'(w[13:0]);
  endfunction

  function automatic int abs_i(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Reference: each peak looks at saturated peaks of its own pixel and of the
  // pixel just before it in the pass (none for pixel 0)
  task automatic build_model();
    exp_bloom = 0;
    for (int p = 0; p < MEM_LEN; p++) begin
      for (int k = 0; k < 4; k++) begin
        int s;
        int d;
        bit near;
        logic [1:0] e;
        s = sig_of(p, k);
        d = dist_of(p, k);
        near = 1'b0;
        for (int j = 0; j < 4; j++) begin
          if (sig_of(p, j) >= SAT && abs_i(d - dist_of(p, j)) <= TOL) near = 1'b1;
          if (p > 0 && sig_of(p-1, j) >= SAT && abs_i(d - dist_of(p-1, j)) <= TOL) near = 1'b1;
        end
        if (s == 0)        e = 2'b11;
        else if (s >= SAT) e = 2'b01;
        else if (near)     e = 2'b10;
        else               e = 2'b00;
        if (e == 2'b10) exp_bloom++;
        exp_not[p][2*k +: 2] = e;
      end
    end
  endtask

  task automatic fill_random();
    for (int p = 0; p < MEM_LEN; p++) begin
      for (int k = 0; k < 4; k++) begin
        int cat;
        int s;
        int d;
        cat = $urandom_range(0, 3);
        if (cat == 0)      s = 0;
        else if (cat == 1) s = SAT + $urandom_range(0, 15);
        else               s = $urandom_range(1, SAT - 1);
        if ($urandom_range(0, 7) == 0) d = $urandom_range(0, 16383);
        else                           d = $urandom_range(0, 40);
        mem[p][k*32 +: 32] = pk(s, d);
      end
    end
  endtask

  function automatic int exp_cnt();
`ifdef BLOOM_STATS_EN
    return exp_bloom;
`else
    return 0;
`endif
  endfunction

  task automatic run_pass(input string tag, input bit start_mid, input bit start_in_done);
    int cyc;
    int w0;
    int missing;
    bit seen;
    build_model();
    pass_id++;
    w0 = wr_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check_val({tag, "_busy_on"}, busy, 1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      start = (start_mid && cyc == 40) || (start_in_done && cyc == 90);
      @(posedge clk); #1;
      cyc++;
      if (bloom_end) seen = 1'b1;
    end
    start = 1'b0;
    check_val({tag, "_end_cycle"}, cyc, 91);
    check_val({tag, "_busy_at_end"}, busy, 0);
    check_val({tag, "_bloom_cnt"}, bloom_cnt, exp_cnt());
    @(posedge clk); #1;
    check_val({tag, "_end_pulse_width"}, bloom_end, 0);
    @(posedge clk); #1;
    check_val({tag, "_busy_idle"}, busy, 0);
    check_val({tag, "_cnt_stable"}, bloom_cnt, exp_cnt());
    check_val({tag, "_wr_count"}, wr_cnt - w0, MEM_LEN);
    missing = 0;
    for (int p = 0; p < MEM_LEN; p++) begin
      if (got_pass[p] != pass_id) missing++;
      check_val($sformatf("%s_not_px%0d", tag, p), got_not[p], exp_not[p]);
    end
    check_val({tag, "_missing_wr"}, missing, 0);
  endtask

  initial begin
    int k;
    int be_seen;
    for (int i = 0; i < 32; i++) begin
      mem[i]      = '0;
      got_not[i]  = '0;
      got_pass[i] = 0;
    end
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_addr", addr, 0);
    check_val("rst_wr_en", wr_en, 0);
    check_val("rst_notation", pn, 0);
    check_val("rst_bloom_end", bloom_end, 0);
    check_val("rst_bloom_cnt", bloom_cnt, 0);
    rst = 1'b0;

    // All-empty memory
    run_pass("zero", 1'b0, 1'b0);
    check_val("zero_px0_const", got_not[0], 8'hFF);

    // Directed bloom cases, including the pixel-0 no-wrap case
    mem[0][31:0]   = pk(10, 50);
    mem[5][31:0]   = pk('h3FFFF, 100);
    mem[5][63:32]  = pk(200, 105);
    mem[6][31:0]   = pk('h3FFFF, 400);
    mem[7][95:64]  = pk(50, 408);
    mem[7][127:96] = pk(50, 409);
    mem[29][31:0]  = pk('h3FFFF, 50);
    run_pass("dir", 1'b0, 1'b0);
    check_val("dir_px5_const", got_not[5], 8'hF9);
    check_val("dir_px6_const", got_not[6], 8'hFD);
    check_val("dir_px7_const", got_not[7], 8'h2F);
    check_val("dir_px0_const", got_not[0], 8'hFC);
`ifdef BLOOM_STATS_EN
    check_val("dir_cnt_const", bloom_cnt, 2);
`else
    check_val("dir_cnt_const", bloom_cnt, 0);
`endif

    // Random pass with threshold / tolerance edges planted at pixel 10
    fill_random();
    mem[9]  = '0;
    mem[11] = '0;
    mem[10] = {pk(5, 992), pk(1, 1009), pk('h3FFEF, 1008), pk('h3FFF0, 1000)};
    run_pass("rnd0", 1'b1, 1'b1);
    check_val("rnd0_px10_const", got_not[10], 8'h89);

    for (int r = 1; r < 4; r++) begin
      fill_random();
      run_pass($sformatf("rnd%0d", r), r[0], r[1]);
    end

    // Reset while pixel 12 is being evaluated
    fill_random();
    pass_id++;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (addr != 5'd12 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check_val("mid_reach_px12", addr, 12);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("mid_rst_wr_en", wr_en, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_addr", addr, 0);
    rst = 1'b0;
    be_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bloom_end) be_seen++;
    end
    check_val("mid_no_bloom_end", be_seen, 0);
    run_pass("restart", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
